// File: rtl/decoder_pkg.sv
// Shared definitions for the pattern decoder and its serial loader front end.
// Pattern width lives here so the decoder and the loader agree on it.
package decoder_pkg;

  localparam int PATTERN_BITS_DEF = 256;
  localparam int WORD_W_DEF       = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WORD = 2'd1,
    SHIFT     = 2'd2,
    DONE      = 2'd3
  } loader_state_t;

  // Counter width for a range of n values; never below one bit so that
  // degenerate configurations still elaborate.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pattern_loader_if.sv
// Word-stream handshake and serial program outputs of the pattern loader.
// "slave" is the loader side, "master" is whoever feeds and watches it.
interface pattern_loader_if
  import decoder_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
);

  logic              start;
  logic              abort;
  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;
  logic              prgm_out;
  logic              prgm_en;
  logic              busy;
  logic              done;

  modport slave (
    input  start, abort, word_in, word_valid,
    output word_ready, prgm_out, prgm_en, busy, done
  );

  modport master (
    output start, abort, word_in, word_valid,
    input  word_ready, prgm_out, prgm_en, busy, done
  );

endinterface

// File: rtl/pattern_loader_piso_word.sv
// One-word parallel-in / serial-out register. Shifts left, so the MSB is
// always the bit currently presented downstream.
module piso_word #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic              i_clear,
  input  logic [WORD_W-1:0] i_word,
  output logic              o_msb
);

  logic [WORD_W-1:0] r_data;
  logic [WORD_W-1:0] w_shifted;

  // Left-shift network: each bit takes its lower neighbour, LSB fills with 0.
  genvar gi;
  generate
    for (gi = 0; gi < WORD_W; gi++) begin : g_shift
      if (gi == 0) begin : g_lsb
        assign w_shifted[gi] = 1'b0;
      end else begin : g_bit
        assign w_shifted[gi] = r_data[gi-1];
      end
    end
  endgenerate

  // Load has priority over shift so a new word can replace the last bit of
  // the previous one in the same cycle.
  always_ff @(posedge clk) begin
    if (clr || i_clear) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_word;
    end else if (i_shift) begin
      r_data <= w_shifted;
    end
  end

  assign o_msb = r_data[WORD_W-1];

endmodule

// File: rtl/pattern_loader.sv
// Byte-wide front end for the pattern decoder: accepts pattern words over a
// valid/ready handshake and serialises them MSB first onto prgm_out with a
// prgm_en strobe, pulsing done once the whole pattern has been shifted.
module pattern_loader
  import decoder_pkg::*;
#(
  parameter int PATTERN_BITS = PATTERN_BITS_DEF,
  parameter int WORD_W       = WORD_W_DEF
) (
  input  logic             clk,
  input  logic             clr,
  pattern_loader_if.slave  bus
);

  localparam int NUM_WORDS = PATTERN_BITS / WORD_W;
  localparam int WCNT_W    = cnt_width(NUM_WORDS);
  localparam int BCNT_W    = cnt_width(WORD_W);

  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NUM_WORDS - 1);
  localparam logic [BCNT_W-1:0] LAST_BIT  = BCNT_W'(WORD_W - 1);

  loader_state_t     r_state;
  loader_state_t     w_state_next;

  logic [WCNT_W-1:0] r_word_cnt;   // index of the word being shifted
  logic [BCNT_W-1:0] r_bit_cnt;    // bit position within that word
  logic              r_prgm_en;

  logic w_last_bit;
  logic w_last_word;
  logic w_word_ready;
  logic w_load;
  logic w_shift;
  logic w_cnt_clr;
  logic w_bit_inc;
  logic w_bit_clr;
  logic w_word_inc;
  logic w_piso_clear;
  logic w_msb;

  assign w_last_bit  = (r_bit_cnt == LAST_BIT);
  assign w_last_word = (r_word_cnt == LAST_WORD);

  // State register.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and datapath controls. Abort is checked before any handshake
  // so a word offered in the abort cycle is never accepted.
  always_comb begin
    w_state_next = r_state;
    w_word_ready = 1'b0;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_cnt_clr    = 1'b0;
    w_bit_inc    = 1'b0;
    w_bit_clr    = 1'b0;
    w_word_inc   = 1'b0;
    w_piso_clear = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_cnt_clr    = 1'b1;
          w_piso_clear = 1'b1;
          w_state_next = WAIT_WORD;
        end
      end

      WAIT_WORD: begin
        if (bus.abort) begin
          w_state_next = IDLE;
        end else begin
          w_word_ready = 1'b1;
          if (bus.word_valid) begin
            w_load       = 1'b1;
            w_state_next = SHIFT;
          end
        end
      end

      SHIFT: begin
        if (bus.abort) begin
          w_state_next = IDLE;
        end else if (!w_last_bit) begin
          w_shift   = 1'b1;
          w_bit_inc = 1'b1;
        end else if (w_last_word) begin
          // Final bit of the pattern: no more words wanted.
          w_shift      = 1'b1;
          w_state_next = DONE;
        end else begin
          // Last bit of a word: offer ready now so the next word can follow
          // without a bubble.
          w_word_ready = 1'b1;
          w_word_inc   = 1'b1;
          w_bit_clr    = 1'b1;
          if (bus.word_valid) begin
            w_load = 1'b1;
          end else begin
            w_shift      = 1'b1;
            w_state_next = WAIT_WORD;
          end
        end
      end

      DONE: begin
        w_state_next = IDLE;
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Word and bit counters; both restart on every start.
  always_ff @(posedge clk) begin
    if (clr || w_cnt_clr) begin
      r_word_cnt <= '0;
      r_bit_cnt  <= '0;
    end else begin
      if (w_word_inc) begin
        r_word_cnt <= r_word_cnt + WCNT_W'(1);
      end
      if (w_bit_clr) begin
        r_bit_cnt <= '0;
      end else if (w_bit_inc) begin
        r_bit_cnt <= r_bit_cnt + BCNT_W'(1);
      end
    end
  end

  // The strobe is high exactly in SHIFT cycles, registered alongside the state.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_prgm_en <= 1'b0;
    end else begin
      r_prgm_en <= (w_state_next == SHIFT);
    end
  end

  piso_word #(
    .WORD_W (WORD_W)
  ) u_piso (
    .clk     (clk),
    .clr     (clr),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_clear (w_piso_clear),
    .i_word  (bus.word_in),
    .o_msb   (w_msb)
  );

  assign bus.word_ready = w_word_ready;
  assign bus.prgm_out   = w_msb;
  assign bus.prgm_en    = r_prgm_en;
  assign bus.busy       = (r_state != IDLE);
  assign bus.done       = (r_state == DONE);

endmodule

// File: tb/tb_pattern_loader.sv
// Directed bench for pattern_loader with the default 256-bit / 8-bit setup.
module tb_pattern_loader;

  logic clk = 1'b0;
  logic clr;

  pattern_loader_if #(.WORD_W(8)) bus ();

  pattern_loader #(
    .PATTERN_BITS (256),
    .WORD_W       (8)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Free-running edge counter: cyc holds the number of rising edges so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Passive observer, sampled on the falling edge.
  logic stream [$];
  int   en_count   = 0;
  int   runs       = 0;
  int   bad_runs   = 0;
  int   run_len    = 0;
  int   rise_cyc   = 0;
  int   done_count = 0;
  int   done_cyc   = 0;
  int   hs_count   = 0;
  logic prev_en    = 1'b0;

  always @(negedge clk) begin
    prev_en <= bus.prgm_en;
    if (bus.prgm_en) begin
      stream.push_back(bus.prgm_out);
      en_count <= en_count + 1;
      if (!prev_en) begin
        runs     <= runs + 1;
        rise_cyc <= cyc;
        run_len  <= 1;
      end else begin
        run_len <= run_len + 1;
      end
    end else if (prev_en && (run_len % 8 != 0)) begin
      bad_runs <= bad_runs + 1;
    end
    if (bus.done) begin
      done_count <= done_count + 1;
      done_cyc   <= cyc;
    end
    if (bus.word_valid && bus.word_ready) begin
      hs_count <= hs_count + 1;
    end
  end

  logic [7:0] pat [32];

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Compare captured serial bits against the words in pat, MSB first.
  task automatic chk_stream(input string tag, input int base, input int nbits);
    int mism;
    mism = 0;
    if (stream.size() < base + nbits) begin
      mism = nbits;
    end else begin
      for (int j = 0; j < nbits; j++) begin
        if (stream[base+j] !== pat[j/8][7-(j%8)]) mism++;
      end
    end
    chk(tag, mism, 0);
  endtask

  function automatic int stream_byte(input int base);
    int v;
    v = 0;
    for (int j = 0; j < 8; j++) begin
      v = (v << 1) | ((stream.size() > base + j && stream[base+j] === 1'b1) ? 1 : 0);
    end
    return v;
  endfunction

  // Runs one load from a start pulse. Words are offered every 'period' cycles,
  // abort is raised once 'abort_words' words have been taken (-1 = never),
  // start is re-pulsed at loop step 'start_k' (-1 = never) and word_valid is
  // optionally held high once all words are gone.
  task automatic run_load(input int period, input int abort_words, input int start_k,
                          input bit valid_after, output int s_edge, output int timed_out);
    int idx;
    int k;
    bit fin;
    idx = 0;
    k   = 0;
    fin = 0;
    bus.start = 1'b1;
    s_edge    = cyc + 1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (!fin && k < 2000) begin
      bus.word_valid = ((idx < 32) || valid_after) && (k % period == 0);
      bus.word_in    = (idx < 32) ? pat[idx] : 8'hFF;
      bus.abort      = (abort_words >= 0) && (idx == abort_words);
      bus.start      = (k == start_k);
      @(negedge clk);
      if (bus.abort) fin = 1;
      else if (bus.word_valid && bus.word_ready) idx++;
      if (bus.done) fin = 1;
      @(posedge clk); #1;
      k++;
    end
    bus.word_valid = 1'b0;
    bus.abort      = 1'b0;
    bus.start      = 1'b0;
    timed_out      = fin ? 0 : 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  int s_edge, to, b_en, b_runs, b_bad, b_done, b_hs, b_str;

  initial begin
    clr            = 1'b1;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.word_in    = 8'h00;
    bus.word_valid = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_word_ready", int'(bus.word_ready), 0);
    chk("rst_prgm_out",   int'(bus.prgm_out),   0);
    chk("rst_prgm_en",    int'(bus.prgm_en),    0);
    chk("rst_busy",       int'(bus.busy),       0);
    chk("rst_done",       int'(bus.done),       0);
    clr = 1'b0;
    @(posedge clk); #1;

    // Full load, words 0x00..0x1F, always valid.
    for (int i = 0; i < 32; i++) pat[i] = 8'(i);
    b_en = en_count; b_runs = runs; b_done = done_count; b_hs = hs_count; b_str = stream.size();
    run_load(1, -1, -1, 1'b0, s_edge, to);
    chk("full_timeout",   to, 0);
    chk("full_en_cycles", en_count - b_en, 256);
    chk("full_en_runs",   runs - b_runs, 1);
    chk("full_first_bit", rise_cyc, s_edge + 1);
    chk("full_handshakes", hs_count - b_hs, 32);
    chk("full_done_count", done_count - b_done, 1);
    // done occupies the cycle ending at edge s_edge+258.
    chk("full_done_cycle", done_cyc, s_edge + 257);
    chk_stream("full_stream", b_str, 256);
    chk("full_word1_bits", stream_byte(b_str + 8), 8'h01);
    chk("full_busy_after", int'(bus.busy), 0);

    // Gapped source: valid only every third cycle.
    b_en = en_count; b_runs = runs; b_bad = bad_runs; b_done = done_count; b_hs = hs_count;
    b_str = stream.size();
    run_load(3, -1, -1, 1'b0, s_edge, to);
    chk("gap_timeout",    to, 0);
    chk("gap_en_cycles",  en_count - b_en, 256);
    chk("gap_split_word", bad_runs - b_bad, 0);
    chk("gap_has_gaps",   int'((runs - b_runs) > 1), 1);
    chk("gap_handshakes", hs_count - b_hs, 32);
    chk("gap_done_count", done_count - b_done, 1);
    chk_stream("gap_stream", b_str, 256);

    // Abort after five words, with a word offered in the abort cycle.
    b_en = en_count; b_done = done_count; b_hs = hs_count; b_str = stream.size();
    run_load(1, 5, -1, 1'b0, s_edge, to);
    chk("abort_timeout",    to, 0);
    chk("abort_busy",       int'(bus.busy), 0);
    chk("abort_prgm_en",    int'(bus.prgm_en), 0);
    chk("abort_handshakes", hs_count - b_hs, 5);
    chk("abort_en_cycles",  en_count - b_en, 33);
    chk_stream("abort_stream", b_str, 33);
    repeat (20) @(posedge clk);
    #1;
    chk("abort_en_quiet",   en_count - b_en, 33);
    chk("abort_no_done",    done_count - b_done, 0);

    // Reset held for two cycles in the middle of shifting.
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start      = 1'b0;
    bus.word_valid = 1'b1;
    bus.word_in    = 8'hFF;
    repeat (12) @(posedge clk);
    #1;
    chk("mid_busy_before", int'(bus.busy), 1);
    clr = 1'b1;
    @(posedge clk); #1;
    chk("clr_word_ready", int'(bus.word_ready), 0);
    chk("clr_prgm_out",   int'(bus.prgm_out),   0);
    chk("clr_prgm_en",    int'(bus.prgm_en),    0);
    chk("clr_busy",       int'(bus.busy),       0);
    chk("clr_done",       int'(bus.done),       0);
    @(posedge clk); #1;
    clr            = 1'b0;
    bus.word_valid = 1'b0;
    @(posedge clk); #1;

    // 0xA5 pattern, start pulsed mid-shift and valid held through DONE.
    for (int i = 0; i < 32; i++) pat[i] = 8'hA5;
    b_en = en_count; b_runs = runs; b_done = done_count; b_hs = hs_count; b_str = stream.size();
    run_load(1, -1, 10, 1'b1, s_edge, to);
    chk("a5_timeout",    to, 0);
    chk("a5_en_cycles",  en_count - b_en, 256);
    chk("a5_en_runs",    runs - b_runs, 1);
    chk("a5_handshakes", hs_count - b_hs, 32);
    chk("a5_done_count", done_count - b_done, 1);
    chk("a5_done_cycle", done_cyc, s_edge + 257);
    chk_stream("a5_stream", b_str, 256);
    chk("a5_last_word",  stream_byte(b_str + 248), 8'hA5);
    chk("a5_busy_after", int'(bus.busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
